// File: rtl/ins_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one read at a time and
// parks returned words in a two-slot ping-pong buffer for decode.
module ins_fetch_unit #(
  parameter int                 ADDR_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic [ADDR_W-1:0] memAddr,
  output logic              memRd,
  input  logic [15:0]       memData,
  input  logic              memValid,
  input  logic              stall,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jumpAddr,
  output logic [15:0]       insIn1,
  output logic [15:0]       insIn2,
  output logic              insel,
  output logic              insValid,
  output logic [ADDR_W-1:0] pcOut
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] PC_ONE = 1;

  state_t state_q;
  state_t state_d;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] head_pc;
  logic [15:0]       slot0;
  logic [15:0]       slot1;
  logic [1:0]        count;
  logic              sel;

  logic ins_valid;
  logic consume;
  logic issue;
  logic accept;
  logic tail;

  assign ins_valid = (count != 2'd0);
  assign consume   = ins_valid & ~stall & ~jump;
  assign accept    = (state_q == WAIT) & memValid & ~jump;
  assign tail      = sel ^ (count == 2'd1);

  // Nothing is in flight while IDLE, so only buffered words limit issue.
  assign issue = (state_q == IDLE) & ~jump & ~rst & (count < 2'd2);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (issue) state_d = WAIT;
      end
      WAIT: begin
        if (memValid)  state_d = IDLE;
        else if (jump) state_d = FLUSH;
      end
      FLUSH: begin
        if (memValid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    memRd   = issue;
    memAddr = issue ? fetch_pc : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      head_pc  <= RESET_PC;
      slot0    <= '0;
      slot1    <= '0;
      count    <= '0;
      sel      <= 1'b0;
    end else if (jump) begin
      fetch_pc <= jumpAddr;
      head_pc  <= jumpAddr;
      count    <= '0;
      sel      <= 1'b0;
    end else begin
      if (issue) fetch_pc <= fetch_pc + PC_ONE;
      if (accept && !tail) slot0 <= memData;
      if (accept && tail)  slot1 <= memData;
      if (consume) begin
        sel     <= ~sel;
        head_pc <= head_pc + PC_ONE;
      end
      count <= count + {1'b0, accept} - {1'b0, consume};
    end
  end

  assign insIn1   = slot0;
  assign insIn2   = slot1;
  assign insel    = sel;
  assign insValid = ins_valid;
  assign pcOut    = head_pc;

endmodule

// File: tb/tb_ins_fetch_unit.sv
// Bench for ins_fetch_unit: directed scenarios then random traffic,
// checked every cycle against a queue-based fetch model.
module tb_ins_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] memAddr;
  logic        memRd;
  logic [15:0] memData;
  logic        memValid;
  logic        stall;
  logic        jump;
  logic [15:0] jumpAddr;
  logic [15:0] insIn1;
  logic [15:0] insIn2;
  logic        insel;
  logic        insValid;
  logic [15:0] pcOut;

  ins_fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0)) dut (
    .clk      (clk),
    .rst      (rst),
    .memAddr  (memAddr),
    .memRd    (memRd),
    .memData  (memData),
    .memValid (memValid),
    .stall    (stall),
    .jump     (jump),
    .jumpAddr (jumpAddr),
    .insIn1   (insIn1),
    .insIn2   (insIn2),
    .insel    (insel),
    .insValid (insValid),
    .pcOut    (pcOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model
  logic [15:0] q[$];
  bit          sel;
  bit          outst;
  bit          drop;
  logic [15:0] fpc;
  logic [15:0] hpc;
  logic [15:0] oaddr;

  // memory responder
  bit          pend;
  int          pend_cnt;
  logic [15:0] pend_addr;
  int          lat_force;
  bit          special1;

  bit          rd_seen;
  logic [15:0] rd_addr;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    if (special1 && a == 16'h0) return 16'h1111;
    return 16'hA000 + a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit s, input bit j,
                      input logic [15:0] ja);
    bit mv;
    bit exp_rd;
    bit cons;
    bit fill;
    @(negedge clk);
    rst      = r;
    stall    = s;
    jump     = j;
    jumpAddr = ja;
    mv       = pend && pend_cnt == 0;
    memValid = mv;
    memData  = mv ? mem_word(pend_addr) : 16'($urandom);
    #1;
    exp_rd = !r && !j && !outst && q.size() < 2;
    chk("memRd", memRd, exp_rd);
    if (exp_rd) chk("memAddr", memAddr, fpc);
    chk("insValid", insValid, q.size() != 0);
    chk("pcOut", pcOut, hpc);
    chk("insel", insel, sel);
    if (q.size() != 0) chk("head", sel ? insIn2 : insIn1, q[0]);
    rd_seen = memRd;
    rd_addr = memAddr;
    @(posedge clk);
    fill = 0;
    if (r) begin
      q.delete();
      sel = 0; outst = 0; drop = 0;
      fpc = 16'h0; hpc = 16'h0;
    end else if (j) begin
      q.delete();
      sel = 0;
      fpc = ja; hpc = ja;
      if (outst) begin
        if (mv) begin outst = 0; drop = 0; end
        else drop = 1;
      end
    end else begin
      cons = q.size() != 0 && !s;
      if (mv && outst) begin
        fill = !drop;
        outst = 0; drop = 0;
      end
      if (cons) begin
        void'(q.pop_front());
        sel = !sel;
        hpc = hpc + 16'd1;
      end
      if (fill) q.push_back(mem_word(oaddr));
      if (exp_rd) begin
        outst = 1; drop = 0;
        oaddr = fpc;
        fpc = fpc + 16'd1;
      end
    end
    if (mv) pend = 0;
    else if (pend && pend_cnt > 0) pend_cnt--;
    if (rd_seen) begin
      pend      = 1;
      pend_addr = rd_addr;
      pend_cnt  = (lat_force != 0 ? lat_force
                                  : int'($urandom_range(1, 3))) - 1;
    end
  endtask

  task automatic do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, 0, 16'h0);
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found;
    rst = 1; stall = 0; jump = 0; jumpAddr = 0;
    memValid = 0; memData = 0;
    sel = 0; outst = 0; drop = 0;
    fpc = 0; hpc = 0; oaddr = 0;
    pend = 0; pend_cnt = 0; pend_addr = 0;
    rd_seen = 0; rd_addr = 0;

    // 1: reset and first fetch
    special1 = 1; lat_force = 1;
    do_reset();
    step(0, 1, 0, 16'h0);
    chk("t1_rd", rd_seen, 1);
    chk("t1_addr", rd_addr, 16'h0);
    step(0, 1, 0, 16'h0);
    settle();
    chk("t1_ins1", insIn1, 16'h1111);
    chk("t1_insel", insel, 0);
    chk("t1_valid", insValid, 1);
    chk("t1_pc", pcOut, 16'h0);

    // 2: fill under stall, then drain
    special1 = 0; lat_force = 0;
    do_reset();
    for (int i = 0; i < 12; i++) step(0, 1, 0, 16'h0);
    settle();
    chk("t2_ins1", insIn1, 16'hA000);
    chk("t2_ins2", insIn2, 16'hA001);
    chk("t2_insel", insel, 0);
    chk("t2_pc", pcOut, 16'h0);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 16'h0);

    // 3: jump while a read is outstanding
    lat_force = 3;
    do_reset();
    step(0, 0, 0, 16'h0);
    step(0, 0, 1, 16'h0040);
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    settle();
    chk("t3_valid", insValid, 0);
    step(0, 0, 0, 16'h0);
    chk("t3_rd", rd_seen, 1);
    chk("t3_addr", rd_addr, 16'h0040);

    // 4: jump beats coincident fill and consume
    lat_force = 1;
    do_reset();
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(0, hpc == 16'd5, 0, 16'h0);
      if (hpc == 16'd5 && q.size() != 0 && pend && pend_cnt == 0)
        found = 1;
    end
    chk("t4_reach", found, 1);
    step(0, 0, 1, 16'h0040);
    settle();
    chk("t4_valid", insValid, 0);
    chk("t4_insel", insel, 0);
    chk("t4_pc", pcOut, 16'h0040);

    // 5: address wrap
    lat_force = 0;
    step(0, 0, 1, 16'hFFFF);
    found = 0;
    for (int i = 0; i < 30; i++) begin
      step(0, 0, 0, 16'h0);
      if (rd_seen && rd_addr == 16'h0) found = 1;
    end
    chk("t5_wrap", found, 1);

    // 6: reset abandons an outstanding read
    lat_force = 3;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      step(0, 0, 0, 16'h0);
      if (rd_seen) found = 1;
    end
    chk("t6_issue", found, 1);
    do_reset();
    chk("t6_pend", pend, 0);
    step(0, 0, 0, 16'h0);
    chk("t6_rd", rd_seen, 1);
    chk("t6_addr", rd_addr, 16'h0);

    // random traffic
    lat_force = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(0, $urandom_range(0, 99) < 30,
             $urandom_range(0, 99) < 5,
             $urandom_range(0, 3) == 0 ? 16'hFFFE : 16'($urandom));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
